// File: rtl/cache_store_load_unit.sv
// Blocking set-associative cache controller: word loads and word/half/byte stores,
// dirty-victim write-back and line refill over a single-beat memory port.
//   state     | meaning
//   IDLE      | ready for a request
//   LOOKUP    | array read data valid; classify error, hit or miss
//   WRITEBACK | write dirty victim line to memory, one word per beat
//   REFILL    | read requested line into the line buffer
//   UPDATE    | write merged line/tag to the array, touch LRU
//   RESP      | one-cycle response
module cache_store_load_unit #(
  parameter int N        = 4,
  parameter int TAG_W    = 18,
  parameter int INDEX_W  = 10,
  parameter int OFFSET_W = 4,
  parameter int DATA_W   = 32,
  localparam int WPL     = 2 ** (OFFSET_W - 2),
  localparam int WAY_W   = (N > 1) ? $clog2(N) : 1,
  localparam int TE_W    = TAG_W + 2,
  localparam int LINE_W  = WPL * DATA_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [4:0]            opcode_i,
  input  logic [2:0]            func3_i,
  input  logic [DATA_W-1:0]     address_i,
  input  logic [DATA_W-1:0]     data_i,
  output logic                  resp_valid_o,
  output logic [DATA_W-1:0]     resp_data_o,
  output logic                  resp_err_o,
  output logic [INDEX_W-1:0]    arr_index_o,
  input  logic [N*TE_W-1:0]     arr_tag_i,
  input  logic [N*LINE_W-1:0]   arr_data_i,
  output logic                  arr_we_o,
  output logic [WAY_W-1:0]      arr_way_o,
  output logic [TE_W-1:0]       arr_tag_o,
  output logic [LINE_W-1:0]     arr_data_o,
  input  logic [WAY_W-1:0]      victim_way_i,
  output logic                  lru_touch_o,
  output logic                  mem_valid_o,
  output logic                  mem_we_o,
  output logic [DATA_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_W-1:0]     mem_rdata_i
);

  localparam int BT_W = OFFSET_W - 2;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOOKUP    = 3'd1;
  localparam logic [2:0] S_WRITEBACK = 3'd2;
  localparam logic [2:0] S_REFILL    = 3'd3;
  localparam logic [2:0] S_UPDATE    = 3'd4;
  localparam logic [2:0] S_RESP      = 3'd5;

  localparam logic [4:0] OP_LOAD  = 5'd11;
  localparam logic [4:0] OP_STORE = 5'd12;
  localparam logic [2:0] F3_WORD  = 3'b010;
  localparam logic [2:0] F3_HALF  = 3'b011;
  localparam logic [2:0] F3_BYTE  = 3'b100;

  logic [2:0]        state_q, state_d;
  logic [4:0]        opcode_q, opcode_d;
  logic [2:0]        func3_q, func3_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [TAG_W-1:0]  vtag_q, vtag_d;
  logic [WAY_W-1:0]  way_q, way_d;
  logic              miss_q, miss_d;
  logic              err_q, err_d;
  logic [BT_W-1:0]   beat_q, beat_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_index;
  logic [BT_W-1:0]    word_sel;
  logic               is_store;
  logic               lookup_err;
  logic               hit;
  logic [WAY_W-1:0]   hit_way;
  logic [TE_W-1:0]    victim_te;
  logic [LINE_W-1:0]  victim_line, hit_line, line_merged;
  logic [DATA_W-1:0]  old_word, new_word;
  logic               last_beat;

  assign req_tag   = addr_q[DATA_W-1 -: TAG_W];
  assign req_index = addr_q[OFFSET_W +: INDEX_W];
  assign word_sel  = addr_q[OFFSET_W-1:2];
  assign is_store  = (opcode_q == OP_STORE);
  assign last_beat = (beat_q == BT_W'(WPL - 1));

  assign victim_te   = arr_tag_i[int'(victim_way_i)*TE_W +: TE_W];
  assign victim_line = arr_data_i[int'(victim_way_i)*LINE_W +: LINE_W];
  assign hit_line    = arr_data_i[int'(hit_way)*LINE_W +: LINE_W];

  // Descending scan so the lowest matching way wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (arr_tag_i[j*TE_W + TAG_W] && (arr_tag_i[j*TE_W +: TAG_W] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(j);
      end
    end
  end

  always_comb begin
    lookup_err = 1'b0;
    if ((opcode_q != OP_LOAD) && (opcode_q != OP_STORE)) begin
      lookup_err = 1'b1;
    end else if (is_store) begin
      if ((func3_q != F3_WORD) && (func3_q != F3_HALF) && (func3_q != F3_BYTE)) begin
        lookup_err = 1'b1;
      end else if ((func3_q == F3_HALF) && addr_q[0]) begin
        lookup_err = 1'b1;
      end
    end
  end

  always_comb begin
    old_word = line_q[int'(word_sel)*DATA_W +: DATA_W];
    new_word = old_word;
    if (is_store) begin
      case (func3_q)
        F3_WORD: new_word = data_q;
        F3_HALF: new_word[16*int'(addr_q[1]) +: 16] = data_q[15:0];
        F3_BYTE: new_word[8*int'(addr_q[1:0]) +: 8] = data_q[7:0];
        default: new_word = old_word;
      endcase
    end
    line_merged = line_q;
    line_merged[int'(word_sel)*DATA_W +: DATA_W] = new_word;
  end

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    func3_d     = func3_q;
    addr_d      = addr_q;
    data_d      = data_q;
    line_d      = line_q;
    vtag_d      = vtag_q;
    way_d       = way_q;
    miss_d      = miss_q;
    err_d       = err_q;
    beat_d      = beat_q;
    resp_data_d = resp_data_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          opcode_d = opcode_i;
          func3_d  = func3_i;
          addr_d   = address_i;
          data_d   = data_i;
          err_d    = 1'b0;
          miss_d   = 1'b0;
          state_d  = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        beat_d = '0;
        if (lookup_err) begin
          err_d       = 1'b1;
          resp_data_d = '0;
          state_d     = S_RESP;
        end else if (hit) begin
          way_d   = hit_way;
          line_d  = hit_line;
          state_d = S_UPDATE;
        end else begin
          // The victim line is latched so write-back words stay stable across beats.
          miss_d  = 1'b1;
          way_d   = victim_way_i;
          line_d  = victim_line;
          vtag_d  = victim_te[TAG_W-1:0];
          state_d = (victim_te[TAG_W+1] && victim_te[TAG_W]) ? S_WRITEBACK : S_REFILL;
        end
      end
      S_WRITEBACK: begin
        if (mem_ack_i) begin
          beat_d = last_beat ? '0 : beat_q + 1'b1;
          if (last_beat) state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        if (mem_ack_i) begin
          line_d[int'(beat_q)*DATA_W +: DATA_W] = mem_rdata_i;
          beat_d = last_beat ? '0 : beat_q + 1'b1;
          if (last_beat) state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        resp_data_d = new_word;
        state_d     = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      opcode_q    <= '0;
      func3_q     <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      line_q      <= '0;
      vtag_q      <= '0;
      way_q       <= '0;
      miss_q      <= 1'b0;
      err_q       <= 1'b0;
      beat_q      <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      func3_q     <= func3_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      line_q      <= line_d;
      vtag_q      <= vtag_d;
      way_q       <= way_d;
      miss_q      <= miss_d;
      err_q       <= err_d;
      beat_q      <= beat_d;
      resp_data_q <= resp_data_d;
    end
  end

  logic upd, in_wb, in_rf;
  assign upd   = (state_q == S_UPDATE);
  assign in_wb = (state_q == S_WRITEBACK);
  assign in_rf = (state_q == S_REFILL);

  assign req_ready_o  = (state_q == S_IDLE);
  assign resp_valid_o = (state_q == S_RESP);
  assign resp_data_o  = resp_valid_o ? resp_data_q : '0;
  assign resp_err_o   = resp_valid_o & err_q;
  assign arr_index_o  = req_index;
  assign arr_we_o     = upd & (is_store | miss_q);
  assign arr_way_o    = upd ? way_q : '0;
  assign arr_tag_o    = upd ? {is_store, 1'b1, req_tag} : '0;
  assign arr_data_o   = upd ? line_merged : '0;
  assign lru_touch_o  = upd;
  assign mem_valid_o  = in_wb | in_rf;
  assign mem_we_o     = in_wb;
  assign mem_addr_o   = in_wb ? {vtag_q, req_index, beat_q, 2'b00} :
                        in_rf ? {req_tag, req_index, beat_q, 2'b00} : '0;
  assign mem_wdata_o  = in_wb ? line_q[int'(beat_q)*DATA_W +: DATA_W] : '0;

endmodule

// File: tb/tb_cache_store_load_unit.sv
// Directed bench for cache_store_load_unit: hits, store merge, dirty/clean misses,
// rejected requests and reset in the middle of a stalled refill.
module tb_cache_store_load_unit;
  localparam int TW = 20;
  localparam int LW = 128;
  localparam logic [31:0] RD_XOR = 32'hC0DE_0000;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_valid_i, req_ready_o;
  logic [4:0]    opcode_i;
  logic [2:0]    func3_i;
  logic [31:0]   address_i, data_i;
  logic          resp_valid_o, resp_err_o;
  logic [31:0]   resp_data_o;
  logic [9:0]    arr_index_o;
  logic [79:0]   arr_tag_i;
  logic [511:0]  arr_data_i;
  logic          arr_we_o;
  logic [1:0]    arr_way_o, victim_way_i;
  logic [19:0]   arr_tag_o;
  logic [127:0]  arr_data_o;
  logic          lru_touch_o;
  logic          mem_valid_o, mem_we_o, mem_ack_i;
  logic [31:0]   mem_addr_o, mem_wdata_o, mem_rdata_i;

  cache_store_load_unit dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .opcode_i(opcode_i), .func3_i(func3_i), .address_i(address_i), .data_i(data_i),
    .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
    .arr_index_o(arr_index_o), .arr_tag_i(arr_tag_i), .arr_data_i(arr_data_i),
    .arr_we_o(arr_we_o), .arr_way_o(arr_way_o), .arr_tag_o(arr_tag_o), .arr_data_o(arr_data_o),
    .victim_way_i(victim_way_i), .lru_touch_o(lru_touch_o),
    .mem_valid_o(mem_valid_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;

  int          nbeats, nwe, ntouch, nresp, nmem, lat;
  logic [31:0] b_addr [16];
  logic        b_we   [16];
  logic [31:0] b_wdata[16];
  logic [127:0] wr_line;
  logic [19:0] wr_tag;
  logic [1:0]  wr_way, touch_way;
  logic [9:0]  touch_idx;
  logic [31:0] r_data;
  logic        r_err;
  logic        stalled;
  logic [31:0] ea, ew;
  logic [127:0] el;

  localparam logic [17:0] TA = 18'h2ABCD;
  localparam logic [9:0]  IA = 10'h155;
  localparam logic [17:0] RT = 18'h00F0F;
  localparam logic [9:0]  IC = 10'h0A5;
  localparam logic [17:0] VT = 18'h12345;
  localparam logic [17:0] RD = 18'h3C3C3;
  localparam logic [9:0]  ID = 10'h3FF;
  localparam logic [17:0] RF = 18'h0AAAA;
  localparam logic [9:0]  IF = 10'h011;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one request and services memory beats with immediate acks until the response.
  // lat is the edge index (acceptance edge = 0) at which a synchronous consumer sees resp_valid_o.
  task automatic run_req(input logic [4:0] op, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk_i);
    chk("ready_at_issue", req_ready_o, 1'b1);
    opcode_i = op; func3_i = f3; address_i = addr; data_i = data; req_valid_i = 1'b1;
    @(posedge clk_i);
    nbeats = 0; nwe = 0; ntouch = 0; nresp = 0; nmem = 0; lat = -1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk_i);
      req_valid_i = 1'b0;
      mem_ack_i   = 1'b0;
      if (mem_valid_o) begin
        nmem++;
        if (nbeats < 16) begin
          b_addr[nbeats] = mem_addr_o; b_we[nbeats] = mem_we_o; b_wdata[nbeats] = mem_wdata_o;
        end
        nbeats++;
        mem_ack_i   = 1'b1;
        mem_rdata_i = mem_addr_o ^ RD_XOR;
      end
      if (arr_we_o) begin
        nwe++; wr_line = arr_data_o; wr_tag = arr_tag_o; wr_way = arr_way_o;
      end
      if (lru_touch_o) begin
        ntouch++; touch_way = arr_way_o; touch_idx = arr_index_o;
      end
      if (resp_valid_o) begin
        nresp++; r_data = resp_data_o; r_err = resp_err_o; lat = cyc + 1;
        break;
      end
      @(posedge clk_i);
    end
  endtask

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b0; opcode_i = '0; func3_i = '0; address_i = '0; data_i = '0;
    arr_tag_i = '0; arr_data_i = '0; victim_way_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("rst_ready", req_ready_o, 1'b1);
    chk("rst_resp_valid", resp_valid_o, 1'b0);
    chk("rst_mem_valid", mem_valid_o, 1'b0);
    chk("rst_arr_we", arr_we_o, 1'b0);
    chk("rst_lru", lru_touch_o, 1'b0);
    chk("rst_index", arr_index_o, 10'h0);

    // Load hit in way 2; way 1 has the tag but is invalid.
    arr_tag_i = '0;
    arr_tag_i[0*TW +: TW] = {2'b01, 18'h00001};
    arr_tag_i[1*TW +: TW] = {2'b00, TA};
    arr_tag_i[2*TW +: TW] = {2'b01, TA};
    arr_tag_i[3*TW +: TW] = {2'b11, 18'h3FFFF};
    arr_data_i = '0;
    arr_data_i[2*LW +: LW] = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
    victim_way_i = 2'd3;
    run_req(5'd11, 3'b010, {TA, IA, 4'h0}, 32'h0);
    chk("ldhit_resp", nresp, 1);
    chk("ldhit_data", r_data, 32'hDEADBEEF);
    chk("ldhit_err", r_err, 1'b0);
    chk("ldhit_lat", lat, 3);
    chk("ldhit_touch", ntouch, 1);
    chk("ldhit_touch_way", touch_way, 2'd2);
    chk("ldhit_index", touch_idx, IA);
    chk("ldhit_no_we", nwe, 0);
    chk("ldhit_no_mem", nmem, 0);

    // Byte store hit, addr[1:0]=2; ways 1 and 3 both match, lowest wins.
    arr_tag_i[2*TW +: TW] = {2'b00, 18'h00002};
    arr_tag_i[1*TW +: TW] = {2'b01, TA};
    arr_tag_i[3*TW +: TW] = {2'b01, TA};
    arr_data_i[1*LW +: LW] = {32'h44444444, 32'h55555555, 32'h11223344, 32'hA0A0A0A0};
    run_req(5'd12, 3'b100, {TA, IA, 4'h6}, 32'hFFFFFFAB);
    chk("stb_resp", nresp, 1);
    chk("stb_data", r_data, 32'h11AB3344);
    chk("stb_lat", lat, 3);
    chk("stb_we", nwe, 1);
    chk("stb_way", wr_way, 2'd1);
    chk("stb_tag", wr_tag, {2'b11, TA});
    chk("stb_line", wr_line, {32'h44444444, 32'h55555555, 32'h11AB3344, 32'hA0A0A0A0});
    chk("stb_no_mem", nmem, 0);

    // Load miss with dirty victim way 1: 4 write-back beats then 4 refill beats.
    arr_tag_i = '0;
    arr_tag_i[0*TW +: TW] = {2'b01, 18'h00001};
    arr_tag_i[1*TW +: TW] = {2'b11, VT};
    arr_tag_i[2*TW +: TW] = {2'b00, RT};
    arr_tag_i[3*TW +: TW] = {2'b01, 18'h3FFFF};
    arr_data_i = '0;
    arr_data_i[1*LW +: LW] = {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};
    victim_way_i = 2'd1;
    run_req(5'd11, 3'b010, {RT, IC, 4'h8}, 32'h0);
    chk("miss_beats", nbeats, 8);
    el = '0;
    for (int k = 0; k < 4; k++) begin
      ea = {VT, IC, 2'(k), 2'b00};
      chk("wb_addr", b_addr[k], ea);
      chk("wb_we", b_we[k], 1'b1);
      chk("wb_data", b_wdata[k], 32'hCAFE0000 + 32'(k));
      ea = {RT, IC, 2'(k), 2'b00};
      chk("rf_addr", b_addr[k+4], ea);
      chk("rf_we", b_we[k+4], 1'b0);
      el[k*32 +: 32] = ea ^ RD_XOR;
    end
    chk("miss_we", nwe, 1);
    chk("miss_way", wr_way, 2'd1);
    chk("miss_tag", wr_tag, {2'b01, RT});
    chk("miss_line", wr_line, el);
    ew = {RT, IC, 2'd2, 2'b00} ^ RD_XOR;
    chk("miss_data", r_data, ew);
    chk("miss_lat", lat, 11);

    // Half store miss, clean victim way 3: refill only, upper half of word 3 replaced.
    arr_tag_i = '0;
    arr_tag_i[3*TW +: TW] = {2'b01, 18'h11111};
    victim_way_i = 2'd3;
    run_req(5'd12, 3'b011, {RD, ID, 4'hE}, 32'h1234BEEF);
    chk("sth_beats", nbeats, 4);
    chk("sth_we0", b_we[0], 1'b0);
    ea = {RD, ID, 2'd0, 2'b00};
    chk("sth_addr0", b_addr[0], ea);
    el = '0;
    for (int k = 0; k < 4; k++) begin
      ea = {RD, ID, 2'(k), 2'b00};
      el[k*32 +: 32] = ea ^ RD_XOR;
    end
    ew = {16'hBEEF, el[96 +: 16]};
    el[96 +: 32] = ew;
    chk("sth_we", nwe, 1);
    chk("sth_way", wr_way, 2'd3);
    chk("sth_tag", wr_tag, {2'b11, RD});
    chk("sth_line", wr_line, el);
    chk("sth_data", r_data, ew);

    // Rejected requests, with a hit available so any array write would be visible.
    arr_tag_i = '0;
    arr_tag_i[0*TW +: TW] = {2'b01, TA};
    victim_way_i = 2'd0;
    run_req(5'd12, 3'b011, {TA, IA, 4'h1}, 32'h5555);
    chk("errh_resp", nresp, 1);
    chk("errh_err", r_err, 1'b1);
    chk("errh_no_we", nwe, 0);
    chk("errh_no_mem", nmem, 0);
    chk("errh_no_touch", ntouch, 0);
    run_req(5'd3, 3'b010, {TA, IA, 4'h0}, 32'h0);
    chk("errop_err", r_err, 1'b1);
    chk("errop_no_touch", ntouch, 0);
    run_req(5'd12, 3'b001, {TA, IA, 4'h0}, 32'h0);
    chk("errf3_err", r_err, 1'b1);
    chk("errf3_no_we", nwe, 0);

    // Reset while refill beat 2 is stalled.
    arr_tag_i = '0;
    arr_tag_i[0*TW +: TW] = {2'b01, 18'h11111};
    victim_way_i = 2'd0;
    @(negedge clk_i);
    opcode_i = 5'd11; func3_i = 3'b010; address_i = {RF, IF, 4'h4}; req_valid_i = 1'b1;
    @(posedge clk_i);
    stalled = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      req_valid_i = 1'b0;
      mem_ack_i   = 1'b0;
      if (mem_valid_o && !mem_we_o && (mem_addr_o[3:2] == 2'd2)) begin
        stalled = 1'b1;
        break;
      end
      if (mem_valid_o) begin
        mem_ack_i = 1'b1; mem_rdata_i = mem_addr_o ^ RD_XOR;
      end
      @(posedge clk_i);
    end
    chk("rst_reach_beat2", stalled, 1'b1);
    ea = {RF, IF, 2'd2, 2'b00};
    repeat (3) begin
      @(posedge clk_i);
      @(negedge clk_i);
      chk("stall_valid", mem_valid_o, 1'b1);
      chk("stall_addr", mem_addr_o, ea);
    end
    rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("mid_rst_ready", req_ready_o, 1'b1);
    chk("mid_rst_mem_valid", mem_valid_o, 1'b0);
    chk("mid_rst_mem_addr", mem_addr_o, 32'h0);
    chk("mid_rst_resp", resp_valid_o, 1'b0);
    chk("mid_rst_we", arr_we_o, 1'b0);
    chk("mid_rst_lru", lru_touch_o, 1'b0);
    nresp = 0;
    repeat (5) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (resp_valid_o) nresp++;
    end
    chk("mid_rst_no_resp", nresp, 0);

    // Unit is usable again after the abort.
    arr_tag_i = '0;
    arr_tag_i[2*TW +: TW] = {2'b01, TA};
    arr_data_i = '0;
    arr_data_i[2*LW +: LW] = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
    run_req(5'd11, 3'b010, {TA, IA, 4'hC}, 32'h0);
    chk("post_rst_data", r_data, 32'h33333333);
    chk("post_rst_lat", lat, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
